// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM states, opcode values and IR field positions for prog_sequencer
package seq_pkg;

    typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_IMM, ISSUE, WAIT, FIN} state_t;

    localparam int OPC_WIDTH = 3;

    localparam logic [OPC_WIDTH-1:0] OPC_MV  = 3'b000;
    localparam logic [OPC_WIDTH-1:0] OPC_MVI = 3'b001;
    localparam logic [OPC_WIDTH-1:0] OPC_ADD = 3'b010;
    localparam logic [OPC_WIDTH-1:0] OPC_SUB = 3'b011;

    function automatic logic is_mvi(input logic [OPC_WIDTH-1:0] opc);
        return opc == OPC_MVI;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: WAIT-phase cycle counter; expired once CYCLES wait cycles have elapsed since clr
module seq_watchdog #(
    parameter int CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    assign expired = cnt >= W'(CYCLES - 1);

    // count enabled cycles, restart on clr, saturate at the expiry point
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= clr ? '0 : (en && !expired) ? cnt + 1'b1 : cnt;
    end

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches a program from memory and issues it to the bus processor
// Optional feature: define SEQ_WATCHDOG_EN to abort a run when proc_done never arrives.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int REG_WIDTH         = 16,
    parameter int INSTRUCTION_WIDTH = 9,
    parameter int ADDR_WIDTH        = 8,
    parameter int WDOG_CYCLES       = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] prog_len,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [REG_WIDTH-1:0]  mem_data,
    output logic                  proc_run,
    output logic [REG_WIDTH-1:0]  proc_din,
    input  logic                  proc_done,
    output logic                  busy,
    output logic                  finished,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] instr_count
);

    state_t                       state;
    logic [ADDR_WIDTH-1:0]        pc, len, pc_nx;
    logic [INSTRUCTION_WIDTH-1:0] op, word_op;
    logic [REG_WIDTH-1:0]         imm, op_ext, word_ext;
    logic                         op_mvi, word_mvi, wd_expired;

    assign pc_nx    = pc + 1'b1;
    assign word_op  = mem_data[INSTRUCTION_WIDTH-1:0];
    assign word_ext = REG_WIDTH'(word_op);
    assign op_ext   = REG_WIDTH'(op);
    assign word_mvi = is_mvi(word_op[INSTRUCTION_WIDTH-1 -: OPC_WIDTH]);
    assign op_mvi   = is_mvi(op[INSTRUCTION_WIDTH-1 -: OPC_WIDTH]);

`ifdef SEQ_WATCHDOG_EN
    seq_watchdog #(.CYCLES(WDOG_CYCLES)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ISSUE),
        .en      (state == WAIT),
        .expired (wd_expired)
    );
`else
    assign wd_expired = WDOG_CYCLES < 0;
`endif

    // sequencer FSM; every output is registered and updated on the transition into its state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            len         <= '0;
            op          <= '0;
            imm         <= '0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            proc_run    <= 1'b0;
            proc_din    <= '0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            error       <= 1'b0;
            instr_count <= '0;
        end else begin
            proc_run <= 1'b0;
            finished <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pc          <= '0;
                    len         <= prog_len;
                    error       <= 1'b0;
                    instr_count <= '0;
                    if (prog_len == '0) begin
                        finished <= 1'b1;
                        state    <= FIN;
                    end else begin
                        busy  <= 1'b1;
                        state <= FETCH_OP;
                    end
                end
                FETCH_OP, FETCH_IMM: if (!mem_rd) begin
                    mem_rd   <= 1'b1;
                    mem_addr <= pc;
                end else if (mem_valid) begin
                    mem_rd <= 1'b0;
                    pc     <= pc_nx;
                    if (state == FETCH_IMM) begin
                        imm      <= mem_data;
                        proc_run <= 1'b1;
                        proc_din <= op_ext;
                        state    <= ISSUE;
                    end else begin
                        op <= word_op;
                        if (!word_mvi) begin
                            proc_run <= 1'b1;
                            proc_din <= word_ext;
                            state    <= ISSUE;
                        end else if (pc_nx == len) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= FETCH_IMM;
                        end
                    end
                end
                ISSUE: begin
                    proc_din <= op_mvi ? imm : op_ext;
                    state    <= WAIT;
                end
                WAIT: if (proc_done) begin
                    instr_count <= instr_count + 1'b1;
                    finished    <= pc == len;
                    state       <= pc == len ? FIN : FETCH_OP;
                end else if (wd_expired) begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed programs against a memory and bus-processor model with per-cycle checks
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  prog_len = '0;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_data = '0;
    logic        proc_run;
    logic [15:0] proc_din;
    logic        proc_done = 1'b0;
    logic        busy, finished, error;
    logic [7:0]  instr_count;

    prog_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_len    (prog_len),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .proc_run    (proc_run),
        .proc_din    (proc_din),
        .proc_done   (proc_done),
        .busy        (busy),
        .finished    (finished),
        .error       (error),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:255];
    logic [15:0] R   [0:7];

    // expected issue list derived from the program image
    logic [15:0] exp_op   [0:31];
    logic [15:0] exp_wait [0:31];
    int          exp_fetch[0:31];
    int          nexp, exp_fetches;
    bit          exp_err;

    // observation state owned by the negedge process
    bit          active = 0, waiting = 0, run_seen = 0, prev_rd = 0, hang = 0;
    logic [7:0]  prev_addr = '0;
    int          idx, exp_cnt, exp_addr, fin_cnt, busy_cyc, fetched, wcnt = 0;
    int          lat = 1, pdly = 1, pstep = 0;
    bit          pbusy = 0;
    logic [8:0]  ir = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // checks DUT outputs against the model, then drives the memory and processor models
    always @(negedge clk) begin
        if (active) begin
            if (proc_done && waiting) begin
                exp_cnt++;
                waiting = 0;
            end
            check("instr_count", instr_count, exp_cnt);
            if (mem_rd && prev_rd)
                check("addr_stable", mem_addr, prev_addr);
            if (mem_rd && !prev_rd) begin
                check("fetch_addr", mem_addr, exp_addr);
                exp_addr++;
            end
            if (proc_run) begin
                check("run_in_range", idx < nexp, 1);
                if (idx < nexp) begin
                    check("issue_din", proc_din, exp_op[idx]);
                    check("issue_fetches", fetched, exp_fetch[idx]);
                end
                idx++;
                waiting = 1;
            end else if (waiting && idx <= nexp) begin
                check("wait_din", proc_din, exp_wait[idx-1]);
            end
            if (finished) fin_cnt++;
            if (busy) busy_cyc++;
        end
        prev_rd   = mem_rd;
        prev_addr = mem_addr;
        if (proc_run) run_seen = 1;
        if (rst) begin
            mem_valid = 0;
            wcnt      = 0;
            pbusy     = 0;
            proc_done = 0;
        end else begin
            if (mem_rd && !mem_valid) begin
                if (wcnt >= lat - 1) begin
                    mem_valid = 1;
                    mem_data  = mem[mem_addr];
                    wcnt      = 0;
                    fetched++;
                end else begin
                    wcnt++;
                end
            end else begin
                mem_valid = 0;
            end
            if (proc_run) begin
                ir        = proc_din[8:0];
                pstep     = pdly;
                pbusy     = 1;
                proc_done = 0;
            end else if (pbusy) begin
                if (pstep <= 1) begin
                    case (ir[8:6])
                        3'b000:  R[ir[5:3]] = R[ir[2:0]];
                        3'b001:  R[ir[5:3]] = proc_din;
                        3'b010:  R[ir[5:3]] = R[ir[5:3]] + R[ir[2:0]];
                        3'b011:  R[ir[5:3]] = R[ir[5:3]] - R[ir[2:0]];
                        default: ;
                    endcase
                    proc_done = !hang;
                    pbusy     = 0;
                end else begin
                    pstep--;
                end
            end else begin
                proc_done = 0;
            end
        end
    end

    task automatic build_model(input int len);
        int a;
        logic [15:0] w;
        nexp = 0;
        exp_err = 0;
        a = 0;
        while (a < len) begin
            w = mem[a] & 16'h01FF;
            a++;
            if (w[8:6] == 3'b001) begin
                if (a == len) begin
                    exp_err = 1;
                    break;
                end
                exp_wait[nexp] = mem[a];
                a++;
            end else begin
                exp_wait[nexp] = w;
            end
            exp_op[nexp]    = w;
            exp_fetch[nexp] = a;
            nexp++;
        end
        exp_fetches = a;
    endtask

    int last_lat;

    task automatic run_prog(input int len, input int l, input int pd);
        int cyc;
        build_model(len);
        @(posedge clk);
        lat = l; pdly = pd; hang = 0;
        idx = 0; exp_cnt = 0; exp_addr = 0; fin_cnt = 0; busy_cyc = 0; fetched = 0; waiting = 0;
        @(negedge clk);
        prog_len = len[7:0];
        start = 1;
        @(posedge clk);
        #1 active = 1;
        for (cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 0;
            if (finished || error) break;
        end
        if (cyc > 400) check("run_timeout", 1, 0);
        last_lat = cyc;
        repeat (3) @(negedge clk);
        active = 0;
        check("finished_cnt", fin_cnt, !exp_err);
        check("error_flag", error, exp_err);
        check("issue_cnt", idx, nexp);
        check("fetch_cnt", exp_addr, exp_fetches);
        check("busy_end", busy, 0);
        check("final_count", instr_count, nexp);
    endtask

    task automatic load(input logic [15:0] w0, w1, w2, w3, w4, w5);
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3; mem[4] = w4; mem[5] = w5;
    endtask

    initial begin
        int cyc, g;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) R[i] = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {mem_rd, mem_addr, proc_run, proc_din, busy, finished, error, instr_count}, 0);
        rst = 0;
        @(negedge clk);

        load(16'h040, 16'h0005, 0, 0, 0, 0);
        run_prog(2, 1, 1);
        check("t1_r0", R[0], 16'h0005);
        check("t1_count", instr_count, 1);

        load(16'h040, 16'h0005, 16'h048, 16'h0003, 16'h081, 0);
        run_prog(5, 1, 1);
        check("t2_r0", R[0], 16'h0008);
        check("t2_r1", R[1], 16'h0003);
        check("t2_count", instr_count, 3);
        check("t2_error", error, 0);

        load(16'h040, 16'h0009, 0, 0, 0, 0);
        run_prog(2, 4, 3);
        check("t3_r0", R[0], 16'h0009);

        run_prog(0, 1, 1);
        check("t4_latency", last_lat <= 2, 1);
        check("t4_busy_cycles", busy_cyc <= 1, 1);
        check("t4_no_read", exp_addr, 0);

        load(16'h040, 0, 0, 0, 0, 0);
        run_prog(1, 1, 1);
        check("t5_error", error, 1);
        check("t5_no_run", idx, 0);
        check("t5_no_finish", fin_cnt, 0);

        load(16'h040, 16'h0005, 0, 0, 0, 0);
        run_prog(2, 2, 1);
        check("t5_error_cleared", error, 0);

        load(16'h040, 16'h0007, 16'h048, 16'h0002, 16'h0C1, 16'h010);
        run_prog(6, 2, 2);
        check("mix_r0", R[0], 16'h0005);
        check("mix_r2", R[2], 16'h0005);
        check("mix_count", instr_count, 4);

        load(16'h040, 16'h0005, 0, 0, 0, 0);
        @(posedge clk);
        hang = 1; lat = 1; pdly = 1; run_seen = 0;
        @(negedge clk);
        prog_len = 8'd2;
        start = 1;
        @(negedge clk);
        start = 0;
        for (cyc = 0; cyc < 50 && !run_seen; cyc++) @(negedge clk);
        check("t6_reach_wait", run_seen, 1);
        repeat (5) @(negedge clk);
        check("t6_wait_busy", busy, 1);
        check("t6_wait_no_error", error, 0);
        #1 rst = 1;
        #1 check("t6_async_reset", {mem_rd, mem_addr, proc_run, proc_din, busy, finished, error, instr_count}, 0);
        @(negedge clk);
        rst = 0;

`ifdef SEQ_WATCHDOG_EN
        @(posedge clk);
        run_seen = 0; fin_cnt = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (cyc = 0; cyc < 50 && !run_seen; cyc++) @(posedge clk);
        #1 g = 0;
        while (!error && g < 60) begin
            if (finished) fin_cnt++;
            @(posedge clk);
            #1 g++;
        end
        check("wdog_cycles", g, 15);
        check("wdog_error", error, 1);
        check("wdog_busy", busy, 0);
        check("wdog_no_finish", fin_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
